// File: rtl/eject_buffer.sv
// Ejection-side flit FIFO between the bufferless router and the local node, with back-pressure and a drop counter.
// Optional same-cycle bypass when the FIFO is empty is enabled by defining EJECT_BYPASS_EN.
module eject_buffer #(
  parameter int FLIT_W = 144,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      eject,
  input  logic                   push,
  output logic                   bfull,
  output logic [FLIT_W-1:0]      node_flit,
  output logic                   node_valid,
  input  logic                   node_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]      CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]      CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              bypass_s, pop_s, accept_s, wr_en_s, drop_s;

`ifdef EJECT_BYPASS_EN
  assign bypass_s = push && (count_q == CNT_ZERO);
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed flit that the node takes immediately is never written.
  always_comb begin
    pop_s    = (count_q != CNT_ZERO) && node_ready;
    accept_s = push && ((count_q != CNT_FULL) || pop_s);
    wr_en_s  = accept_s && !(bypass_s && node_ready);
    drop_s   = push && !accept_s;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_en_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_en_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end

    if (drop_s && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // Node-facing head; forced to zero when nothing is held so reset never exposes stale storage.
  always_comb begin
    node_valid = (count_q != CNT_ZERO) || bypass_s;
    if (count_q != CNT_ZERO) begin
      node_flit = mem_q[rd_ptr_q];
    end else if (bypass_s) begin
      node_flit = eject;
    end else begin
      node_flit = {FLIT_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= CNT_ZERO;
      drop_q   <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Flit storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= eject;
    end
  end

  assign bfull    = (count_q == CNT_FULL);
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_eject_buffer.sv
// Self-checking bench for eject_buffer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_eject_buffer;

  localparam int FLIT_W = 144;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam logic [FLIT_W-1:0] SINGLE = 144'h00000000000000000123456789abcdef1857;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] eject;
  logic              push;
  logic              bfull;
  logic [FLIT_W-1:0] node_flit;
  logic              node_valid;
  logic              node_ready;
  logic [2:0]        count;
  logic [CNT_W-1:0]  drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [FLIT_W-1:0] mq[$];
  int                m_drops;
  bit                collect;
  logic [FLIT_W-1:0] deliv[$];

  always #5 clk = ~clk;

  eject_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .eject     (eject),
    .push      (push),
    .bfull     (bfull),
    .node_flit (node_flit),
    .node_valid(node_valid),
    .node_ready(node_ready),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  function automatic logic [FLIT_W-1:0] mk(input int i);
    return {16'hF1A7, 96'(i), 32'hC0DE_0000 | 32'(i)};
  endfunction

  task automatic check(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, applied from the current inputs.
  task automatic model_update();
    int sz;
    bit popped;
    bit bypassed;
    if (!rst) return;
    sz       = mq.size();
    popped   = (sz != 0) && node_ready;
    bypassed = 1'b0;
`ifdef EJECT_BYPASS_EN
    bypassed = (sz == 0) && push && node_ready;
`endif
    if (popped) void'(mq.pop_front());
    if (push && !bypassed) begin
      if (sz < DEPTH || popped) mq.push_back(eject);
      else if (m_drops < (1 << CNT_W) - 1) m_drops++;
    end
  endtask

  task automatic drive(input logic p, input logic [FLIT_W-1:0] d, input logic r);
    push       = p;
    eject      = d;
    node_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic              exp_valid;
    logic [FLIT_W-1:0] exp_flit;
    forever begin
      @(negedge clk);
      exp_valid = (mq.size() != 0);
      exp_flit  = (mq.size() != 0) ? mq[0] : {FLIT_W{1'b0}};
`ifdef EJECT_BYPASS_EN
      if (rst && mq.size() == 0 && push) begin
        exp_valid = 1'b1;
        exp_flit  = eject;
      end
`endif
      check("m_count", FLIT_W'(count), FLIT_W'(mq.size()));
      check("m_valid", FLIT_W'(node_valid), FLIT_W'(exp_valid));
      check("m_bfull", FLIT_W'(bfull), FLIT_W'(mq.size() == DEPTH));
      check("m_flit", node_flit, exp_flit);
      check("m_drop", FLIT_W'(drop_cnt), FLIT_W'(m_drops));
      if (collect && node_valid && node_ready) deliv.push_back(node_flit);
    end
  end

  initial begin
    logic [FLIT_W-1:0] drain_exp[4];
    logic [FLIT_W-1:0] pushed[$];
    int  sent;
    bit  rdy;
    bit  p;

    rst = 1'b0; m_drops = 0; collect = 1'b0;
    drive(1'b0, {FLIT_W{1'b0}}, 1'b0);
    #2;
    check("rst_count", FLIT_W'(count), FLIT_W'(0));
    check("rst_valid", FLIT_W'(node_valid), FLIT_W'(0));
    check("rst_bfull", FLIT_W'(bfull), FLIT_W'(0));
    check("rst_flit", node_flit, {FLIT_W{1'b0}});
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Single flit with the node ready.
    drive(1'b1, SINGLE, 1'b1);
    #1;
`ifdef EJECT_BYPASS_EN
    check("byp_flit", node_flit, SINGLE);
    check("byp_valid", FLIT_W'(node_valid), FLIT_W'(1));
`endif
    tick();
    drive(1'b0, {FLIT_W{1'b0}}, 1'b1);
    #1;
`ifdef EJECT_BYPASS_EN
    check("byp_count", FLIT_W'(count), FLIT_W'(0));
    check("byp_after", FLIT_W'(node_valid), FLIT_W'(0));
`else
    check("single_flit", node_flit, SINGLE);
    check("single_valid", FLIT_W'(node_valid), FLIT_W'(1));
`endif
    tick();
    #1;
    check("single_once", FLIT_W'(node_valid), FLIT_W'(0));

    // Fill to full without the node consuming.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(i), 1'b0);
      tick();
    end
    drive(1'b0, {FLIT_W{1'b0}}, 1'b0);
    #1;
    check("fill_count", FLIT_W'(count), FLIT_W'(4));
    check("fill_bfull", FLIT_W'(bfull), FLIT_W'(1));
    check("fill_head", node_flit, mk(0));

    // Overflow: two pushes into a full FIFO are dropped.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(100 + i), 1'b0);
      tick();
    end
    drive(1'b0, {FLIT_W{1'b0}}, 1'b0);
    #1;
    check("ovf_drop", FLIT_W'(drop_cnt), FLIT_W'(2));
    check("ovf_count", FLIT_W'(count), FLIT_W'(4));
    check("ovf_head", node_flit, mk(0));

    // Push and pop together while full.
    drive(1'b1, mk(200), 1'b1);
    tick();
    drive(1'b0, {FLIT_W{1'b0}}, 1'b0);
    #1;
    check("pp_count", FLIT_W'(count), FLIT_W'(4));
    check("pp_drop", FLIT_W'(drop_cnt), FLIT_W'(2));
    check("pp_head", node_flit, mk(1));

    drain_exp[0] = mk(1); drain_exp[1] = mk(2); drain_exp[2] = mk(3); drain_exp[3] = mk(200);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, {FLIT_W{1'b0}}, 1'b1);
      #1;
      check("drain_order", node_flit, drain_exp[k]);
      tick();
      if (k == 0) check("drain_bfull", FLIT_W'(bfull), FLIT_W'(0));
    end
    #1;
    check("drain_empty", FLIT_W'(node_valid), FLIT_W'(0));

    // Asynchronous reset with three flits stored.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(300 + i), 1'b0);
      tick();
    end
    drive(1'b0, {FLIT_W{1'b0}}, 1'b0);
    #2;
    rst = 1'b0;
    mq.delete();
    m_drops = 0;
    #1;
    check("arst_count", FLIT_W'(count), FLIT_W'(0));
    check("arst_valid", FLIT_W'(node_valid), FLIT_W'(0));
    check("arst_bfull", FLIT_W'(bfull), FLIT_W'(0));
    check("arst_drop", FLIT_W'(drop_cnt), FLIT_W'(0));
    check("arst_flit", node_flit, {FLIT_W{1'b0}});
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    #1;
    check("post_rst_empty", FLIT_W'(node_valid), FLIT_W'(0));

    // Pointer wrap: router pushes whenever bfull is low, node ready toggles.
    collect = 1'b1;
    sent = 0;
    rdy  = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      p = (sent < 10) && !bfull;
      drive(p, mk(400 + sent), rdy);
      if (p) begin
        pushed.push_back(mk(400 + sent));
        sent++;
      end
      rdy = !rdy;
      check("wrap_count_max", FLIT_W'(count <= 3'd4), FLIT_W'(1));
      tick();
      if (sent == 10 && mq.size() == 0) break;
    end
    collect = 1'b0;
    drive(1'b0, {FLIT_W{1'b0}}, 1'b0);
    #1;
    check("wrap_sent", FLIT_W'(sent), FLIT_W'(10));
    check("wrap_empty", FLIT_W'(count), FLIT_W'(0));
    check("wrap_drop", FLIT_W'(drop_cnt), FLIT_W'(0));
    check("wrap_ndeliv", FLIT_W'(deliv.size()), FLIT_W'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < deliv.size()) check("wrap_order", deliv[i], mk(400 + i));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eject_buffer.md
# eject_buffer

Ejection-side flit buffer directly downstream of `connectRouter_nobuffer`. It captures every flit the router presents on `eject` with `push`, and holds it in a small FIFO until the local node consumes it over a valid/ready handshake. It drives the router's `bfull` input so that the bufferless router stops ejecting when no storage is left. It also counts flits dropped on overflow for debug.

## Interface
- `FLIT_W`, 144: flit width; matches `` `control_w ``.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `CNT_W`, 8: width of the drop counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous and active-low.
- `eject`  in  FLIT_W  flit from the router's ejection port.
- `push`  in  1  `eject` is valid this cycle.
- `bfull`  out  1  to router: buffer cannot accept a flit.
- `node_flit`  out  FLIT_W  head flit offered to the node.
- `node_valid`  out  1  `node_flit` is valid.
- `node_ready`  in  1  node accepts `node_flit` this cycle.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `drop_cnt`  out  CNT_W  saturating count of dropped flits.

## Operation
- **Storage.** Circular FIFO with write pointer, read pointer and `count` registers. Pointers wrap modulo DEPTH.
- **Pop.** A pop occurs when `node_valid & node_ready`. The read pointer advances.
- **Push acceptance.** A push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle. An accepted flit is written at the write pointer and the write pointer advances.
- **Drop.** A push that is not accepted is dropped. `drop_cnt` increments by 1 and saturates at 2^CNT_W−1. Neither the FIFO nor `count` changes.
- **Count update.** `count` next value = count + accepted_push − pop.
- **bfull.** `bfull = (count == DEPTH)`, decoded from the registered `count` only, with no combinational path from `push` or `node_ready`.
- **Node outputs.** `node_valid = (count != 0)`. `node_flit` is the FIFO entry at the read pointer, except on the bypass path (see Configuration).
- **Flit contents.** Flit contents are not inspected or modified; bit-exact passthrough.
- **No FSM.** The only state is the pointers, `count` and `drop_cnt`.

## Timing
- **Reset.** While `rst` = 0: pointers, `count` and `drop_cnt` are 0, `node_valid` = 0, `bfull` = 0, and `node_flit` = 0. Reset is asynchronous on assertion. Release is sampled at the next rising `clk`.
- **Reset mid-operation.** Reset discards all stored flits. No flit is presented after reset until a new push occurs.
- **Latency (macro off).** A flit pushed at edge N is presented on `node_flit`/`node_valid` after edge N, i.e. 1 cycle of latency.
- **Throughput.** One flit per cycle in and one flit per cycle out. A simultaneous push and pop leaves `count` unchanged at any occupancy.
- **bfull timing.** `bfull` rises in the cycle after the edge at which the DEPTH-th entry is written. It falls in the cycle after the first pop from full. The router must sample `bfull` before asserting `push`.
- **Empty with pop.** `node_ready` = 1 while empty has no effect.
- **Full with push, no pop.** The flit is dropped and `drop_cnt` increments.

## Configuration
- **Macro `EJECT_BYPASS_EN` defined.**
  - When `count == 0` and `push` = 1, the block drives `node_valid` = 1 and `node_flit = eject` combinationally in the same cycle.
  - If `node_ready` = 1 in that cycle, the flit is consumed directly. It is not written and `count` stays 0.
  - If `node_ready` = 0, the flit is written normally.
  - Zero-cycle latency when empty.
- **Macro not defined.** There is no combinational path from `eject`/`push` to the node outputs, and latency is always 1 cycle.
- **Common to both.** Behaviour is identical in both builds whenever `count > 0`.

## Test plan
- **Reset check.** Assert `rst` = 0 mid-stream with 3 flits stored → `count` = 0, `node_valid` = 0, `bfull` = 0, `drop_cnt` = 0 immediately, with no clock edge needed.
- **Single flit.**
  - Stimulus: push `144'h00000000000000000123456789abcdef1857` with `node_ready` = 1.
  - Macro off: `node_flit` equals that value one cycle later, for one cycle only.
  - Macro on: `node_flit` equals that value in the same cycle and `count` stays 0.
- **Fill.** Push 4 distinct flits with `node_ready` = 0 → `count` = 4 and `bfull` = 1 after the 4th edge. Then raise `node_ready` → flits emerge in push order and `bfull` = 0 after the first pop.
- **Overflow.** With the FIFO full and `node_ready` = 0, push 2 more flits → `drop_cnt` = 2, and the stored contents are unchanged.
- **Full push+pop.** With the FIFO full, push and pop in the same cycle → push accepted, `count` stays 4, `drop_cnt` unchanged, and the new flit emerges 4th.
- **Pointer wrap.** Run 10 back-to-back flits with `node_ready` toggling every cycle → all flits delivered in order, `drop_cnt` = 0, and `count` never exceeds 4.
